// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: fixed instruction words, fetch FSM encoding
// and the base opcodes used by the control units.
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_target_gen.sv
// Redirect target generator: converts a sign-extended byte offset into a word
// offset and adds it to the branch PC, wrapping modulo 2^PC_WIDTH.
module fetch_target_gen #(
  parameter int PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic [31:0]         br_imm,
  output logic [PC_WIDTH-1:0] target
);

  // Bits above the PC range only carry sign extension, and the low two bits
  // are a byte offset inside a word; neither affects a word-addressed PC.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{br_imm[31:PC_WIDTH+2], br_imm[1:0]};

  // Truncating the word offset to PC_WIDTH makes the add wrap in both
  // directions: a negative offset is its two's complement modulo 2^PC_WIDTH.
  logic [PC_WIDTH-1:0] word_off;
  assign word_off = br_imm[PC_WIDTH+1:2];
  assign target   = br_pc + word_off;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, presents it combinationally to the
// instruction memory, registers the returned word and its PC into the IF
// output stage with a valid/ready handshake, applies branch redirects and
// halts on ECALL.
// Optional build macro FETCH_PERF_EN adds fetch and stall event counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  input  logic                br_valid,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic [31:0]         br_imm,
  output logic                halted,
  output logic                busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] br_target;
  logic                load;
  logic                accept;

  fetch_target_gen #(
    .PC_WIDTH (PC_WIDTH)
  ) u_target_gen (
    .br_pc  (br_pc),
    .br_imm (br_imm),
    .target (br_target)
  );

  assign imem_addr = pc;

  // A redirect wins over a fetch: the word at the current pc is wrong-path.
  assign load   = (state == FETCH_RUN) & ~br_valid & (~if_valid | if_ready);
  assign accept = if_valid & if_ready;

  // Fetch FSM with the PC and the IF output stage; busy/halted track the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= INSTR_NOP;
      if_pc    <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        FETCH_IDLE: begin
          // A branch arriving with start is ignored; fetch begins at RESET_PC.
          if (start) begin
            state <= FETCH_RUN;
            pc    <= RESET_PC;
            busy  <= 1'b1;
          end
        end
        FETCH_RUN, FETCH_HALT: begin
          if (br_valid) begin
            state    <= FETCH_RUN;
            pc       <= br_target;
            if_valid <= 1'b0;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end else if (load) begin
            if_instr <= imem_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 1'b1;
            if (imem_data == INSTR_ECALL) begin
              state  <= FETCH_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          end else if (accept) begin
            if_valid <= 1'b0;
          end
        end
        default: begin
          state  <= FETCH_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_evt;
  assign stall_evt = (state == FETCH_RUN) & if_valid & ~if_ready;

  // Event counters: loads and RUN-state backpressure cycles, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int PW    = 10;
  localparam int DEPTH = 1 << PW;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [PW-1:0] if_pc;
  logic          br_valid;
  logic [PW-1:0] br_pc;
  logic [31:0]   br_imm;
  logic          halted;
  logic          busy;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  logic [31:0] imem [DEPTH];
  assign imem_data = imem[imem_addr];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .br_imm    (br_imm),
    .halted    (halted),
    .busy      (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    br_valid = 1'b0;
    br_pc    = '0;
    br_imm   = '0;
    if_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},  {31'd0, if_valid}, 32'd0);
    check({tag, "_instr"},  if_instr, NOP);
    check({tag, "_pc"},     {22'd0, if_pc}, 32'd0);
    check({tag, "_addr"},   {22'd0, imem_addr}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_pfetch"}, perf_fetch_cnt, 32'd0);
    check({tag, "_pstall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_mode;     // 0 idle, 1 running, 2 halted
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_opc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  function automatic int wrap_pc(input int v);
    return ((v % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_valid = 0;
    m_instr = NOP;
    m_opc   = 0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // Applies one clock of the fetch rules to the model using the current inputs.
  task automatic model_step();
    int word_off;
    if (m_mode == 1 && m_valid && !if_ready) m_stall = m_stall + 1;
    if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end else if (br_valid) begin
      word_off = $signed(br_imm) >>> 2;
      m_pc     = wrap_pc(int'(br_pc) + word_off);
      m_valid  = 0;
      m_mode   = 1;
    end else if (m_mode == 1 && (!m_valid || if_ready)) begin
      m_instr = imem[m_pc];
      m_opc   = m_pc;
      m_valid = 1;
      m_fetch = m_fetch + 1;
      if (imem[m_pc] == ECALL) m_mode = 2;
      m_pc = wrap_pc(m_pc + 1);
    end else if (m_valid && if_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic model_compare(input int cyc);
    check($sformatf("rnd%0d_valid", cyc), {31'd0, if_valid}, {31'd0, m_valid});
    check($sformatf("rnd%0d_addr", cyc), {22'd0, imem_addr}, 32'(m_pc));
    check($sformatf("rnd%0d_busy", cyc), {31'd0, busy}, {31'd0, m_mode == 1});
    check($sformatf("rnd%0d_halted", cyc), {31'd0, halted}, {31'd0, m_mode == 2});
    if (m_valid) begin
      check($sformatf("rnd%0d_instr", cyc), if_instr, m_instr);
      check($sformatf("rnd%0d_ifpc", cyc), {22'd0, if_pc}, 32'(m_opc));
    end
`ifdef FETCH_PERF_EN
    check($sformatf("rnd%0d_pfetch", cyc), perf_fetch_cnt, m_fetch);
    check($sformatf("rnd%0d_pstall", cyc), perf_stall_cnt, m_stall);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          start;
    logic          br_valid;
    logic [PW-1:0] br_pc;
    logic [31:0]   br_imm;
    logic          ready;
    logic          exp_valid;
    logic [31:0]   exp_instr;
    logic [PW-1:0] exp_pc;
    logic [PW-1:0] exp_addr;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [13];

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) imem[i] = 32'(i + 100);

    vecs[0]  = '{1'b1, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 32'd0,   10'd0,    10'd0,    1'b1};
    vecs[1]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd100, 10'd0,    10'd1,    1'b1};
    vecs[2]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd101, 10'd1,    10'd2,    1'b1};
    vecs[3]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd102, 10'd2,    10'd3,    1'b1};
    vecs[4]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 32'd102, 10'd2,    10'd3,    1'b1};
    vecs[5]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 32'd102, 10'd2,    10'd3,    1'b1};
    vecs[6]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 32'd102, 10'd2,    10'd3,    1'b1};
    vecs[7]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd103, 10'd3,    10'd4,    1'b1};
    vecs[8]  = '{1'b0, 1'b1, 10'd5, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'd0,   10'd0,    10'd3,    1'b1};
    vecs[9]  = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd103, 10'd3,    10'd4,    1'b1};
    vecs[10] = '{1'b0, 1'b1, 10'd1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'd0,   10'd0,    10'd1023, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd1123,10'd1023, 10'd0,    1'b1};
    vecs[12] = '{1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b1, 32'd100, 10'd0,    10'd1,    1'b1};

    // ---- reset values, then streaming / stall / redirect / wrap table ----
    do_reset();
    #1;
    check_reset_state("rst");
    for (int i = 0; i < 13; i++) begin
      start    = vecs[i].start;
      br_valid = vecs[i].br_valid;
      br_pc    = vecs[i].br_pc;
      br_imm   = vecs[i].br_imm;
      if_ready = vecs[i].ready;
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_addr", i), {22'd0, imem_addr}, {22'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
        check($sformatf("v%0d_ifpc", i), {22'd0, if_pc}, {22'd0, vecs[i].exp_pc});
      end
    end
    idle_inputs();
`ifdef FETCH_PERF_EN
    check("tbl_pfetch", perf_fetch_cnt, 32'd7);
    check("tbl_pstall", perf_stall_cnt, 32'd3);
`endif

    // ---- ECALL halt, hold until accepted, then resume via branch ----
    imem[4] = ECALL;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ec_instr",  if_instr, ECALL);
    check("ec_ifpc",   {22'd0, if_pc}, 32'd4);
    check("ec_valid",  {31'd0, if_valid}, 32'd1);
    check("ec_halted", {31'd0, halted}, 32'd1);
    check("ec_busy",   {31'd0, busy}, 32'd0);
    if_ready = 1'b0;
    tick();
    tick();
    check("ec_hold_valid", {31'd0, if_valid}, 32'd1);
    check("ec_hold_instr", if_instr, ECALL);
    if_ready = 1'b1;
    tick();
    check("ec_acc_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("ec_idle_valid", {31'd0, if_valid}, 32'd0);
    check("ec_idle_addr",  {22'd0, imem_addr}, 32'd5);
`ifdef FETCH_PERF_EN
    check("ec_pfetch", perf_fetch_cnt, 32'd5);
`endif
    br_valid = 1'b1;
    br_pc    = 10'd4;
    br_imm   = 32'hFFFF_FFF0;
    tick();
    br_valid = 1'b0;
    check("ec_br_busy",   {31'd0, busy}, 32'd1);
    check("ec_br_halted", {31'd0, halted}, 32'd0);
    check("ec_br_addr",   {22'd0, imem_addr}, 32'd0);
    tick();
    check("ec_res_valid", {31'd0, if_valid}, 32'd1);
    check("ec_res_instr", if_instr, 32'd100);
    check("ec_res_ifpc",  {22'd0, if_pc}, 32'd0);
    imem[4] = 32'd104;

    // ---- asynchronous reset while stalled with a valid word ----
    if_ready = 1'b0;
    tick();
    tick();
    check("ar_pre_valid", {31'd0, if_valid}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("ar");
    @(negedge clk);
    rst_n    = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("ar_post_valid", {31'd0, if_valid}, 32'd0);
    check("ar_post_busy",  {31'd0, busy}, 32'd0);
    check("ar_post_addr",  {22'd0, imem_addr}, 32'd0);

    // ---- start together with br_valid in IDLE, then start while running ----
    start    = 1'b1;
    br_valid = 1'b1;
    br_pc    = 10'd50;
    br_imm   = 32'd40;
    tick();
    start    = 1'b0;
    br_valid = 1'b0;
    check("sb_busy", {31'd0, busy}, 32'd1);
    check("sb_addr", {22'd0, imem_addr}, 32'd0);
    tick();
    check("sb_ifpc",  {22'd0, if_pc}, 32'd0);
    check("sb_instr", if_instr, 32'd100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sr_ifpc", {22'd0, if_pc}, 32'd1);
    check("sr_addr", {22'd0, imem_addr}, 32'd2);
    check("sr_busy", {31'd0, busy}, 32'd1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < DEPTH; i++)
      imem[i] = ($urandom_range(0, 99) < 4) ? ECALL : $urandom();
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 1000 == 999) begin
        do_reset();
        model_reset();
      end
      start    = ($urandom_range(0, 99) < 8);
      br_valid = ($urandom_range(0, 99) < 10);
      br_pc    = PW'($urandom());
      br_imm   = $urandom();
      if_ready = ($urandom_range(0, 99) < 70);
      model_step();
      tick();
      model_compare(cyc);
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
